// File: rtl/hvac_thermostat_sequencer.sv
// Thermostat sequencer: turns temperature samples into one-cycle command pulses for the HVAC mode FSM.
// Optional command refresh is compiled in when HVAC_SEQ_REFRESH_EN is defined.
module hvac_thermostat_sequencer #(
   parameter int TEMP_W          = 8,
   parameter int HYST            = 2,
   parameter int MIN_RUN_CYCLES  = 16,
   parameter int MIN_IDLE_CYCLES = 8,
   parameter int REFRESH_CYCLES  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [TEMP_W-1:0] temp,
   input  logic [TEMP_W-1:0] setpoint,
   input  logic              sample_valid,
   output logic              cmd_on,
   output logic              cmd_heat,
   output logic              cmd_cool,
   output logic              cmd_off,
   output logic [1:0]        state_o,
   output logic              lockout
);

   localparam int SW        = TEMP_W + 2;
   localparam int DWELL_MAX = (MIN_RUN_CYCLES > MIN_IDLE_CYCLES) ? MIN_RUN_CYCLES : MIN_IDLE_CYCLES;
   localparam int DW        = $clog2(DWELL_MAX + 1);
   localparam logic [DW-1:0] DWELL_SAT = DW'(DWELL_MAX);
   localparam logic [DW-1:0] RUN_MIN   = DW'(MIN_RUN_CYCLES);
   localparam logic [DW-1:0] IDLE_MIN  = DW'(MIN_IDLE_CYCLES);

   if (REFRESH_CYCLES < 2) begin : gBadRefresh
      $error("REFRESH_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {S_OFF = 2'd0, S_IDLE = 2'd1, S_HEAT = 2'd2, S_COOL = 2'd3} state_t;
   typedef enum logic [1:0] {D_NONE = 2'd0, D_HEAT = 2'd1, D_COOL = 2'd2} demand_t;

   state_t            state, stateNext;
   demand_t           demand, demandNext, demandSample;
   logic [DW-1:0]     dwell, dwellNext;
   logic              lockoutNext;
   logic [3:0]        cmd, cmdNext;
   logic signed [SW-1:0] tempS, spS, hystS;

   // Widened signed thresholds so setpoint-HYST below zero or setpoint+HYST past full scale compare correctly
   always_comb begin
      tempS        = $signed({2'b00, temp});
      spS          = $signed({2'b00, setpoint});
      hystS        = $signed(SW'(HYST));
      demandSample = D_NONE;
      if ((tempS < spS - hystS) || (state == S_HEAT && tempS < spS))
         demandSample = D_HEAT;
      else if ((tempS > spS + hystS) || (state == S_COOL && tempS > spS))
         demandSample = D_COOL;
      demandNext = sample_valid ? demandSample : demand;
   end

   // Transition rules in priority order; disable is a safety override that ignores dwell
   always_comb begin
      stateNext = state;
      if (!enable && state != S_OFF)
         stateNext = S_OFF;
      else if (state == S_OFF && enable)
         stateNext = S_IDLE;
      else if (state == S_IDLE && demand != D_NONE && dwell >= IDLE_MIN)
         stateNext = (demand == D_HEAT) ? S_HEAT : S_COOL;
      else if (((state == S_HEAT && demand != D_HEAT) || (state == S_COOL && demand != D_COOL))
               && dwell >= RUN_MIN)
         stateNext = S_IDLE;

      if (stateNext != state)
         dwellNext = '0;
      else if (dwell == DWELL_SAT)
         dwellNext = dwell;
      else
         dwellNext = dwell + DW'(1);

      lockoutNext = enable &&
         ((stateNext == S_IDLE && demandNext != D_NONE && dwellNext < IDLE_MIN) ||
          (stateNext == S_HEAT && demandNext != D_HEAT && dwellNext < RUN_MIN) ||
          (stateNext == S_COOL && demandNext != D_COOL && dwellNext < RUN_MIN));
   end

   function automatic logic [3:0] cmdFor(state_t s);
      case (s)
         S_OFF:   cmdFor = 4'b0001;
         S_IDLE:  cmdFor = 4'b1000;
         S_HEAT:  cmdFor = 4'b1100;
         default: cmdFor = 4'b1010;
      endcase
   endfunction

`ifdef HVAC_SEQ_REFRESH_EN
   localparam int RW = $clog2(REFRESH_CYCLES);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

   logic [RW-1:0] refreshCnt;
   logic          refreshFire;

   assign refreshFire = (stateNext == state) && (refreshCnt == REFRESH_LAST);

   // Counts cycles since the last pulse so a stable state re-issues its commands periodically
   always_ff @(posedge clk) begin
      if (reset || stateNext != state || refreshFire)
         refreshCnt <= '0;
      else
         refreshCnt <= refreshCnt + RW'(1);
   end
`endif

   // Entry pulses take precedence over any refresh pulse
   always_comb begin
      cmdNext = 4'b0000;
      if (stateNext != state)
         cmdNext = cmdFor(stateNext);
`ifdef HVAC_SEQ_REFRESH_EN
      else if (refreshFire)
         cmdNext = cmdFor(state);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_OFF;
         demand  <= D_NONE;
         dwell   <= '0;
         cmd     <= 4'b0000;
         lockout <= 1'b0;
      end else begin
         state   <= stateNext;
         demand  <= demandNext;
         dwell   <= dwellNext;
         cmd     <= cmdNext;
         lockout <= lockoutNext;
      end
   end

   assign {cmd_on, cmd_heat, cmd_cool, cmd_off} = cmd;
   assign state_o = state;

endmodule

// File: tb/tb_hvac_thermostat_sequencer.sv
// Bench for hvac_thermostat_sequencer: directed vector table, corner sequences and a randomized run
// against a rule-level reference model (define HVAC_SEQ_REFRESH_EN to exercise refresh).
module tb_hvac_thermostat_sequencer;

   localparam int HYST     = 2;
   localparam int MIN_RUN  = 16;
   localparam int MIN_IDLE = 8;
   localparam int REFRESH  = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] temp = 8'd70;
   logic [7:0] setpoint = 8'd70;
   logic       sample_valid = 1'b0;
   logic       cmd_on, cmd_heat, cmd_cool, cmd_off, lockout;
   logic [1:0] state_o;

   int compared = 0;
   int mismatched = 0;

   hvac_thermostat_sequencer #(
      .TEMP_W(8), .HYST(HYST), .MIN_RUN_CYCLES(MIN_RUN),
      .MIN_IDLE_CYCLES(MIN_IDLE), .REFRESH_CYCLES(REFRESH)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .temp(temp), .setpoint(setpoint),
      .sample_valid(sample_valid), .cmd_on(cmd_on), .cmd_heat(cmd_heat), .cmd_cool(cmd_cool),
      .cmd_off(cmd_off), .state_o(state_o), .lockout(lockout)
   );

   always #5 clk = ~clk;

   // Reference model: states 0 OFF 1 IDLE 2 HEAT 3 COOL; demand 0 none 1 heat 2 cool; since = cycles since entry
   int         mState = 0, mDemand = 0, mSince = 0;
   logic [3:0] mCmd = 4'b0000;
   logic       mLock = 1'b0;

   function automatic logic [3:0] cmdOf(int s);
      case (s)
         0:       return 4'b0001;
         1:       return 4'b1000;
         2:       return 4'b1100;
         default: return 4'b1010;
      endcase
   endfunction

   // The state the rules want to reach ignoring dwell, and the dwell that move needs
   task automatic wantOf(input int s, input int dem, input logic en, output int tgt, output int need);
      tgt = s;
      need = 0;
      if (!en && s != 0) tgt = 0;
      else if (s == 0 && en) tgt = 1;
      else if (s == 1 && dem != 0) begin tgt = (dem == 1) ? 2 : 3; need = MIN_IDLE; end
      else if ((s == 2 && dem != 1) || (s == 3 && dem != 2)) begin tgt = 1; need = MIN_RUN; end
   endtask

   task automatic modelStep();
      int t, sp, newDem, tgt, need, nxt;
      if (reset) begin
         mState = 0; mDemand = 0; mSince = 0; mCmd = 4'b0000; mLock = 1'b0;
         return;
      end
      t = int'(temp);
      sp = int'(setpoint);
      newDem = mDemand;
      if (sample_valid) begin
         if (t < sp - HYST || (mState == 2 && t < sp)) newDem = 1;
         else if (t > sp + HYST || (mState == 3 && t > sp)) newDem = 2;
         else newDem = 0;
      end
      wantOf(mState, mDemand, enable, tgt, need);
      nxt = (mSince >= need) ? tgt : mState;
      mDemand = newDem;
      mCmd = 4'b0000;
      if (nxt != mState) begin
         mCmd = cmdOf(nxt);
         mSince = 0;
      end else begin
         mSince++;
`ifdef HVAC_SEQ_REFRESH_EN
         if (mSince % REFRESH == 0) mCmd = cmdOf(mState);
`endif
      end
      mState = nxt;
      wantOf(mState, mDemand, enable, tgt, need);
      mLock = (tgt != mState) && (mSince < need);
   endtask

   function automatic logic [6:0] dutVec();
      return {state_o, cmd_on, cmd_heat, cmd_cool, cmd_off, lockout};
   endfunction

   task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got state=%0d cmd(on,heat,cool,off)=%b lockout=%b, required state=%0d cmd=%b lockout=%b",
                  name, $time, act[6:5], act[4:1], act[0], exp[6:5], exp[4:1], exp[0]);
      end
   endtask

   // One clock: the model advances on the same edge as the DUT, outputs are compared 1ns later
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("model", dutVec(), {mState[1:0], mCmd, mLock});
   endtask

   typedef struct {
      logic       en;
      logic       sv;
      int         t;
      int         sp;
      int         hold;
      logic [1:0] st;
      logic [3:0] cmd;
      logic       lock;
   } vec_t;

   vec_t tbl[32];

   task automatic applyStimulus(input vec_t v);
      enable = v.en;
      sample_valid = v.sv;
      temp = v.t[7:0];
      setpoint = v.sp[7:0];
      tick();
      sample_valid = 1'b0;
      repeat (v.hold) tick();
   endtask

   initial begin
      int pulses, waited;
      logic [6:0] expVec;

      tbl[0]  = '{1'b1, 1'b0,  70,  70,  0, 2'd1, 4'b1000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0,  70,  70,  0, 2'd1, 4'b0000, 1'b0};
      tbl[2]  = '{1'b1, 1'b1,  65,  70,  0, 2'd1, 4'b0000, 1'b1};
      tbl[3]  = '{1'b1, 1'b0,  70,  70,  5, 2'd1, 4'b0000, 1'b0};
      tbl[4]  = '{1'b1, 1'b0,  70,  70,  0, 2'd2, 4'b1100, 1'b0};
      tbl[5]  = '{1'b1, 1'b0,  70,  70,  3, 2'd2, 4'b0000, 1'b0};
      tbl[6]  = '{1'b1, 1'b1,  70,  70,  0, 2'd2, 4'b0000, 1'b1};
      tbl[7]  = '{1'b1, 1'b0,  70,  70,  9, 2'd2, 4'b0000, 1'b1};
      tbl[8]  = '{1'b1, 1'b0,  70,  70,  0, 2'd2, 4'b0000, 1'b0};
      tbl[9]  = '{1'b1, 1'b0,  70,  70,  0, 2'd1, 4'b1000, 1'b0};
      tbl[10] = '{1'b1, 1'b1,  68,  70,  0, 2'd1, 4'b0000, 1'b0};
      tbl[11] = '{1'b1, 1'b1,  72,  70,  0, 2'd1, 4'b0000, 1'b0};
      tbl[12] = '{1'b1, 1'b1,  75,  70,  0, 2'd1, 4'b0000, 1'b1};
      tbl[13] = '{1'b1, 1'b0,  70,  70,  4, 2'd1, 4'b0000, 1'b0};
      tbl[14] = '{1'b1, 1'b0,  70,  70,  0, 2'd3, 4'b1010, 1'b0};
      tbl[15] = '{1'b1, 1'b0,  70,  70,  5, 2'd3, 4'b0000, 1'b0};
      tbl[16] = '{1'b1, 1'b1,  71,  70,  0, 2'd3, 4'b0000, 1'b0};
      tbl[17] = '{1'b1, 1'b1,  65,  70,  0, 2'd3, 4'b0000, 1'b1};
      tbl[18] = '{1'b1, 1'b0,  70,  70,  7, 2'd3, 4'b0000, 1'b0};
      tbl[19] = '{1'b1, 1'b0,  70,  70,  0, 2'd1, 4'b1000, 1'b1};
      tbl[20] = '{1'b1, 1'b0,  70,  70,  7, 2'd1, 4'b0000, 1'b0};
      tbl[21] = '{1'b1, 1'b0,  70,  70,  0, 2'd2, 4'b1100, 1'b0};
      tbl[22] = '{1'b1, 1'b1,  69,  70,  0, 2'd2, 4'b0000, 1'b0};
      tbl[23] = '{1'b1, 1'b0,  70,  70,  1, 2'd2, 4'b0000, 1'b0};
      tbl[24] = '{1'b0, 1'b0,  70,  70,  0, 2'd0, 4'b0001, 1'b0};
      tbl[25] = '{1'b0, 1'b0,  70,  70,  0, 2'd0, 4'b0000, 1'b0};
      tbl[26] = '{1'b1, 1'b0,  70,  70,  0, 2'd1, 4'b1000, 1'b1};
      tbl[27] = '{1'b1, 1'b1,   0,   1,  0, 2'd1, 4'b0000, 1'b0};
      tbl[28] = '{1'b1, 1'b1, 255, 254,  0, 2'd1, 4'b0000, 1'b0};
      tbl[29] = '{1'b1, 1'b0,  70,  70, 10, 2'd1, 4'b0000, 1'b0};
      tbl[30] = '{1'b0, 1'b1,  60,  70,  0, 2'd0, 4'b0001, 1'b0};
      tbl[31] = '{1'b1, 1'b0,  70,  70,  0, 2'd1, 4'b1000, 1'b1};

      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      checkOutput("reset_state", dutVec(), 7'b00_0000_0);

      for (int i = 0; i < 32; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vector%0d", i), dutVec(), {tbl[i].st, tbl[i].cmd, tbl[i].lock});
      end

      // Reset on the edge that would otherwise enter IDLE suppresses the pulse entirely
      enable = 1'b0;
      tick();
      checkOutput("disable_pulse", dutVec(), 7'b00_0001_0);
      reset = 1'b1;
      enable = 1'b1;
      tick();
      checkOutput("reset_blocks_pulse", dutVec(), 7'b00_0000_0);
      reset = 1'b0;
      tick();
      checkOutput("post_reset_idle", dutVec(), 7'b01_1000_0);

      // Hold HEAT and count repeated command pulses
      temp = 8'd60;
      setpoint = 8'd70;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      waited = 0;
      while (state_o != 2'd2 && waited < 40) begin
         tick();
         waited++;
      end
      checkOutput("reach_heat", {state_o, 5'b0}, {2'd2, 5'b0});
      pulses = 0;
      repeat (140) begin
         tick();
         if (cmd_on || cmd_heat || cmd_cool || cmd_off) pulses++;
      end
`ifdef HVAC_SEQ_REFRESH_EN
      expVec = 7'd2;
`else
      expVec = 7'd0;
`endif
      checkOutput("refresh_count", 7'(pulses), expVec);

      // Randomized run, every cycle compared against the model
      for (int n = 0; n < 4000; n++) begin
         int sp, t;
         reset = ($urandom_range(0, 999) < 3);
         enable = ($urandom_range(0, 99) < 97);
         sample_valid = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 19) == 0) begin
            sp = $urandom_range(0, 255);
            t = $urandom_range(0, 255);
         end else begin
            sp = 60 + $urandom_range(0, 20);
            t = sp + $urandom_range(0, 12) - 6;
         end
         setpoint = sp[7:0];
         temp = t[7:0];
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
